// File: rtl/mux_8to1_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 8:1 serial mux path.
// Eight requesters compete for the single output line. A grant lasts until
// the holder drops its request or the burst limit is reached. One idle
// cycle always separates consecutive grants. The requester just served
// then has the lowest priority in the next arbitration.
module mux_8to1_rr_arbiter #(
  parameter int MAX_BURST = 8  // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] i,
  output logic [7:0] gnt,
  output logic [2:0] s,
  output logic       o,
  output logic       valid,
  output logic       busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Count value on which a burst is forcibly ended.
  localparam logic [7:0] LP_LAST = 8'(MAX_BURST - 1);

  state_t     r_state;
  logic [2:0] r_ptr;    // highest-priority requester for the next arbitration
  logic [2:0] r_s;
  logic [7:0] r_gnt;
  logic [7:0] r_cnt;    // cycles already spent in the current burst

  logic       w_found;
  logic [2:0] w_winner;
  logic [2:0] w_idx;
  logic       w_busy;
  logic       w_valid;
  logic       w_release;

  // Rotating priority search: first active request at ptr, ptr+1, ... (mod 8).
  always_comb begin
    // NOTE: every signal gets a default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int k = 0; k < 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_busy    = (r_state == ST_BUSY);
  assign w_valid   = w_busy && req[r_s];
  assign w_release = !req[r_s] || (r_cnt == LP_LAST);

  // Arbitration FSM: grant, count the burst, release and advance the pointer.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so that every
    // right-hand side sees the values from before this edge.
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 3'd0;
      r_s     <= 3'd0;
      r_gnt   <= 8'h00;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_s     <= w_winner;
            r_gnt   <= 8'h01 << w_winner;
            r_cnt   <= 8'd0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            // s is kept so the output select does not move during the gap.
            r_state <= ST_IDLE;
            r_gnt   <= 8'h00;
            r_cnt   <= 8'd0;
            r_ptr   <= r_s + 3'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 8'h00;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign s     = r_s;
  assign busy  = w_busy;
  assign valid = w_valid;
  assign o     = w_valid & i[r_s];

endmodule

// File: tb/tb_mux_8to1_rr_arbiter.sv
// Directed testbench for mux_8to1_rr_arbiter with MAX_BURST = 8.
// Observed vector layout: {gnt[7:0], s[2:0], valid, o, busy}.
module tb_mux_8to1_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] i;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       o;
  logic       valid;
  logic       busy;

  int n_cmp;
  int n_err;

  logic [13:0] obs;
  assign obs = {gnt, s, valid, o, busy};

  mux_8to1_rr_arbiter #(.MAX_BURST(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .i    (i),
    .gnt  (gnt),
    .s    (s),
    .o    (o),
    .valid(valid),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs an expected output vector in the same layout as obs.
  function automatic logic [13:0] ev(input logic [7:0] g, input logic [2:0] sel,
                                     input logic v, input logic od, input logic b);
    return {g, sel, v, od, b};
  endfunction

  // Advance one clock edge, then apply the inputs for the next edge.
  // Outputs read after this task show the state after the edge and the
  // combinational response to the new inputs.
  task automatic step(input logic [7:0] rv, input logic [7:0] iv);
    @(posedge clk);
    #1;
    req = rv;
    i   = iv;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step(8'h00, 8'h00);
    step(8'h00, 8'h00);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 8'hFF;
    i   = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      step(8'hFF, 8'hFF);
      n_cmp++;
      if (obs !== ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %h want %h", c, obs, ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
      end
    end
    rst = 1'b0;
    req = 8'h00;
    i   = 8'h00;
  endtask

  task automatic test_single_burst;
    logic [7:0] iv;
    req = 8'h08;
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < 8; c++) begin
        iv = (c % 2 == 1) ? 8'h08 : 8'h00;
        step(8'h08, iv);
        n_cmp++;
        if (obs !== ev(8'h08, 3'd3, 1'b1, iv[3], 1'b1)) begin
          n_err++;
          $display("FAIL single rep%0d cyc%0d: got %h want %h", rep, c, obs,
                   ev(8'h08, 3'd3, 1'b1, iv[3], 1'b1));
        end
      end
      step((rep == 0) ? 8'h08 : 8'h00, 8'hFF);
      n_cmp++;
      if (obs !== ev(8'h00, 3'd3, 1'b0, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL single gap%0d: got %h want %h", rep, obs, ev(8'h00, 3'd3, 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] iv;
    logic [2:0] k;
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      k = 3'(g % 8);
      for (int c = 0; c < 8; c++) begin
        iv = 8'($urandom);
        step(8'hFF, iv);
        n_cmp++;
        if (obs !== ev(8'h01 << k, k, 1'b1, iv[k], 1'b1)) begin
          n_err++;
          $display("FAIL rr grant%0d cyc%0d: got %h want %h", g, c, obs,
                   ev(8'h01 << k, k, 1'b1, iv[k], 1'b1));
        end
      end
      step((g == 8) ? 8'h00 : 8'hFF, 8'hFF);
      n_cmp++;
      if (obs !== ev(8'h00, k, 1'b0, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL rr gap%0d: got %h want %h", g, obs, ev(8'h00, k, 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  // Pointer is 1 here: grant 5, drop early, then 6 beats 2.
  task automatic test_early_release;
    logic [7:0] rv [9] = '{8'h20, 8'h20, 8'h00, 8'h44, 8'h44, 8'h04, 8'h04, 8'h00, 8'h00};
    logic [7:0] iv [9] = '{8'h20, 8'h00, 8'h20, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    logic [13:0] ex [9];
    ex[0] = ev(8'h20, 3'd5, 1'b1, 1'b1, 1'b1);
    ex[1] = ev(8'h20, 3'd5, 1'b1, 1'b0, 1'b1);
    ex[2] = ev(8'h20, 3'd5, 1'b0, 1'b0, 1'b1);
    ex[3] = ev(8'h00, 3'd5, 1'b0, 1'b0, 1'b0);
    ex[4] = ev(8'h40, 3'd6, 1'b1, 1'b1, 1'b1);
    ex[5] = ev(8'h40, 3'd6, 1'b0, 1'b0, 1'b1);
    ex[6] = ev(8'h00, 3'd6, 1'b0, 1'b0, 1'b0);
    ex[7] = ev(8'h04, 3'd2, 1'b0, 1'b0, 1'b1);
    ex[8] = ev(8'h00, 3'd2, 1'b0, 1'b0, 1'b0);
    req = 8'h20;
    for (int c = 0; c < 9; c++) begin
      step(rv[c], iv[c]);
      n_cmp++;
      if (obs !== ex[c]) begin
        n_err++;
        $display("FAIL early cyc%0d: got %h want %h", c, obs, ex[c]);
      end
    end
  endtask

  // Pointer is 3 here: serve 7, pointer wraps to 0, so 0 wins over 7.
  task automatic test_wrap;
    logic [7:0] rv [7] = '{8'h80, 8'h01, 8'h81, 8'h80, 8'h80, 8'h00, 8'h00};
    logic [7:0] iv [7] = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    logic [13:0] ex [7];
    ex[0] = ev(8'h80, 3'd7, 1'b1, 1'b1, 1'b1);
    ex[1] = ev(8'h80, 3'd7, 1'b0, 1'b0, 1'b1);
    ex[2] = ev(8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
    ex[3] = ev(8'h01, 3'd0, 1'b0, 1'b0, 1'b1);
    ex[4] = ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    ex[5] = ev(8'h80, 3'd7, 1'b0, 1'b0, 1'b1);
    ex[6] = ev(8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
    req = 8'h80;
    for (int c = 0; c < 7; c++) begin
      step(rv[c], iv[c]);
      n_cmp++;
      if (obs !== ex[c]) begin
        n_err++;
        $display("FAIL wrap cyc%0d: got %h want %h", c, obs, ex[c]);
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [7:0] iv;
    req = 8'h04;
    for (int c = 0; c < 4; c++) begin
      iv = (c % 2 == 0) ? 8'h04 : 8'h00;
      step(8'h04, iv);
      n_cmp++;
      if (obs !== ev(8'h04, 3'd2, 1'b1, iv[2], 1'b1)) begin
        n_err++;
        $display("FAIL midrst burst cyc%0d: got %h want %h", c, obs,
                 ev(8'h04, 3'd2, 1'b1, iv[2], 1'b1));
      end
    end
    rst = 1'b1;
    step(8'h04, 8'hFF);
    n_cmp++;
    if (obs !== ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b0)) begin
      n_err++;
      $display("FAIL midrst after: got %h want %h", obs, ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    end
    rst = 1'b0;
    step(8'h04, 8'h04);
    n_cmp++;
    if (obs !== ev(8'h04, 3'd2, 1'b1, 1'b1, 1'b1)) begin
      n_err++;
      $display("FAIL midrst regrant: got %h want %h", obs, ev(8'h04, 3'd2, 1'b1, 1'b1, 1'b1));
    end
    step(8'h00, 8'h00);
    step(8'h00, 8'h00);
    n_cmp++;
    if (obs !== ev(8'h00, 3'd2, 1'b0, 1'b0, 1'b0)) begin
      n_err++;
      $display("FAIL midrst idle: got %h want %h", obs, ev(8'h00, 3'd2, 1'b0, 1'b0, 1'b0));
    end
  endtask

  // Pointer is 3 here: request drops on the final count cycle of a burst.
  task automatic test_back_to_back;
    logic [7:0] iv;
    req = 8'h0A;
    for (int c = 0; c < 7; c++) begin
      iv = 8'($urandom);
      step(8'h0A, iv);
      n_cmp++;
      if (obs !== ev(8'h08, 3'd3, 1'b1, iv[3], 1'b1)) begin
        n_err++;
        $display("FAIL b2b cyc%0d: got %h want %h", c, obs, ev(8'h08, 3'd3, 1'b1, iv[3], 1'b1));
      end
    end
    step(8'h02, 8'hFF);
    n_cmp++;
    if (obs !== ev(8'h08, 3'd3, 1'b0, 1'b0, 1'b1)) begin
      n_err++;
      $display("FAIL b2b last: got %h want %h", obs, ev(8'h08, 3'd3, 1'b0, 1'b0, 1'b1));
    end
    step(8'h02, 8'hFF);
    n_cmp++;
    if (obs !== ev(8'h00, 3'd3, 1'b0, 1'b0, 1'b0)) begin
      n_err++;
      $display("FAIL b2b gap: got %h want %h", obs, ev(8'h00, 3'd3, 1'b0, 1'b0, 1'b0));
    end
    step(8'h00, 8'hFF);
    n_cmp++;
    if (obs !== ev(8'h02, 3'd1, 1'b0, 1'b0, 1'b1)) begin
      n_err++;
      $display("FAIL b2b next: got %h want %h", obs, ev(8'h02, 3'd1, 1'b0, 1'b0, 1'b1));
    end
    step(8'h00, 8'h00);
    n_cmp++;
    if (obs !== ev(8'h00, 3'd1, 1'b0, 1'b0, 1'b0)) begin
      n_err++;
      $display("FAIL b2b end: got %h want %h", obs, ev(8'h00, 3'd1, 1'b0, 1'b0, 1'b0));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = 8'hFF;
    i     = 8'hFF;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_early_release();
    test_wrap();
    test_reset_mid_burst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
